// File: rtl/sr_cmd_driver_if.sv
// Command-side bundle for sr_cmd_driver: request handshake plus completion/status.
// master = control logic issuing commands, slave = the driver.
interface sr_cmd_driver_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       done;
  logic       err;
  logic       q_shadow;

  modport master (
    output req_valid,
    output req_op,
    input  req_ready,
    input  done,
    input  err,
    input  q_shadow
  );

  modport slave (
    input  req_valid,
    input  req_op,
    output req_ready,
    output done,
    output err,
    output q_shadow
  );
endinterface

// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver: turns hold/set/reset/toggle requests into single legal S or R
// pulses for a registered SR flop, waits SETTLE_CYC cycles, checks the fed-back Q
// and reports completion with a status bit.
// Optional build macro SR_DRV_RETRY_EN: on a Q mismatch, re-drive up to MAX_RETRY
// extra times before reporting an error. Without it the first mismatch is an error.
module sr_cmd_driver #(
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic           clk,
  input  logic           n_rst,
  sr_cmd_driver_if.slave cmd,
  output logic           S_o,
  output logic           R_o,
  input  logic           Q_fb_i
);

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // Settle counter holds values 1..SETTLE_CYC while in WAIT.
  localparam int WAIT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYC);

  // Reject nonsensical configurations at elaboration time.
  if (SETTLE_CYC < 0 || MAX_RETRY < 0) begin : g_bad_cfg
    $error("sr_cmd_driver: SETTLE_CYC and MAX_RETRY must be non-negative");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_RESP
  } state_t;

  state_t              state_q;
  logic                s_q;
  logic                r_q;
  logic                done_q;
  logic                err_q;
  logic                qsh_q;
  logic                target_q;
  logic                hold_q;
  logic [WAIT_W-1:0]   wait_q;

`ifdef SR_DRV_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0]  retry_q;
`endif

  logic accept_d;
  logic target_d;

  // Accept decode and the value the flop must end up at for the offered op.
  always_comb begin
    accept_d = cmd.req_valid && (state_q == ST_IDLE);
    target_d = Q_fb_i;
    case (cmd.req_op)
      OP_HOLD:   target_d = Q_fb_i;
      OP_SET:    target_d = 1'b1;
      OP_RESET:  target_d = 1'b0;
      OP_TOGGLE: target_d = ~Q_fb_i;
      default:   target_d = Q_fb_i;
    endcase
  end

  // Command FSM; every output is a register so S/R reach the flop glitch-free.
  // S and R are always written as a complementary pair gated by a single pulse,
  // so they can never be high together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      qsh_q    <= 1'b0;
      target_q <= 1'b0;
      hold_q   <= 1'b0;
      wait_q   <= '0;
`ifdef SR_DRV_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            target_q <= target_d;
            hold_q   <= (cmd.req_op == OP_HOLD);
`ifdef SR_DRV_RETRY_EN
            retry_q  <= '0;
`endif
            if (cmd.req_op == OP_HOLD) begin
              // Hold issues no pulse; it spends its single cycle of latency in
              // CHECK so its completion appears one cycle after accept.
              state_q <= ST_CHECK;
            end else begin
              state_q <= ST_DRIVE;
              s_q     <= target_d;
              r_q     <= ~target_d;
            end
          end
        end

        ST_DRIVE: begin
          wait_q  <= WAIT_ONE;
          state_q <= (SETTLE_CYC == 0) ? ST_CHECK : ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= ST_CHECK;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        ST_CHECK: begin
          if (hold_q || (Q_fb_i == target_q)) begin
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            qsh_q   <= Q_fb_i;
          end else begin
`ifdef SR_DRV_RETRY_EN
            if (retry_q < RETRY_MAX) begin
              // Re-drive the same pulse; the counter saturates at RETRY_MAX.
              retry_q <= retry_q + 1'b1;
              state_q <= ST_DRIVE;
              s_q     <= target_q;
              r_q     <= ~target_q;
            end else begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              qsh_q   <= Q_fb_i;
            end
`else
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            qsh_q   <= Q_fb_i;
`endif
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.req_ready = (state_q == ST_IDLE);
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.q_shadow  = qsh_q;
  assign S_o           = s_q;
  assign R_o           = r_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: two drivers (SETTLE_CYC=1 and SETTLE_CYC=0), each
// closing the loop through a behavioural SR flop. Expectations come from a
// command-level model: target value, attempt count and completion latency.
module tb_sr_cmd_driver;

  localparam int WIN = 14;

`ifdef SR_DRV_RETRY_EN
  localparam int FAULT_ATTEMPTS = 2 + 1;
`else
  localparam int FAULT_ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sr_cmd_driver_if if0 ();
  sr_cmd_driver_if if1 ();

  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  int         req_sel = 0;
  logic       force_en = 1'b0;

  logic S0, R0, S1, R1, q0, q1, qfb0;
  logic o_S, o_R, o_ready, o_done, o_err, o_qs;

  int n_checks = 0;
  int n_fail   = 0;
  logic mq0 = 1'b0;
  logic mq1 = 1'b0;

  assign if0.req_valid = req_valid && (req_sel == 0);
  assign if1.req_valid = req_valid && (req_sel == 1);
  assign if0.req_op    = req_op;
  assign if1.req_op    = req_op;
  assign qfb0          = force_en ? 1'b0 : q0;

  sr_cmd_driver #(.SETTLE_CYC(1), .MAX_RETRY(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .cmd(if0), .S_o(S0), .R_o(R0), .Q_fb_i(qfb0));
  sr_cmd_driver #(.SETTLE_CYC(0), .MAX_RETRY(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .cmd(if1), .S_o(S1), .R_o(R1), .Q_fb_i(q1));

  // Behavioural registered SR flops in the loop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q0 <= 1'b0;
      q1 <= 1'b0;
    end else begin
      if (S0 && !R0) q0 <= 1'b1;
      else if (R0 && !S0) q0 <= 1'b0;
      if (S1 && !R1) q1 <= 1'b1;
      else if (R1 && !S1) q1 <= 1'b0;
    end
  end

  assign o_S     = (req_sel == 1) ? S1 : S0;
  assign o_R     = (req_sel == 1) ? R1 : R0;
  assign o_ready = (req_sel == 1) ? if1.req_ready : if0.req_ready;
  assign o_done  = (req_sel == 1) ? if1.done : if0.done;
  assign o_err   = (req_sel == 1) ? if1.err : if0.err;
  assign o_qs    = (req_sel == 1) ? if1.q_shadow : if0.q_shadow;

  // Model: where the flop must end up for an op, given its current value.
  function automatic logic model_target(input logic [1:0] op, input logic q);
    case (op)
      2'b01:   return 1'b1;
      2'b10:   return 1'b0;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // Model: cycle index (1 = cycle right after the accept edge) in which done is high.
  function automatic int model_done_k(input logic [1:0] op, input int attempts, input int settle);
    if (op == 2'b00) return 2;
    return attempts * (2 + settle) + 1;
  endfunction

  // Offer one command, wait (bounded) for accept, then record a WIN-cycle window.
  task automatic capture(input int s, input logic [1:0] op, input int rel_after,
                         output bit acc, output int ns, output int nr, output int fp,
                         output int dk, output int dc, output logic e, output logic qs,
                         output int ov);
    int waitc;
    acc = 0; ns = 0; nr = 0; fp = 0; dk = 0; dc = 0; e = 1'bx; qs = 1'bx; ov = 0;
    @(negedge clk);
    req_sel = s;
    req_op = op;
    req_valid = 1'b1;
    waitc = 0;
    #1;
    while (!o_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!o_ready) begin
      req_valid = 1'b0;
      return;
    end
    acc = 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (o_S || o_R) begin
        if (fp == 0) fp = k;
      end
      if (o_S) begin
        ns++;
        if (rel_after > 0 && ns == rel_after) force_en = 1'b0;
      end
      if (o_R) nr++;
      if (o_S && o_R) ov++;
      if (o_done) begin
        dc++;
        if (dk == 0) begin
          dk = k;
          e = o_err;
          qs = o_qs;
        end
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (S0 !== 1'b0) begin n_fail++; $display("FAIL reset_S: got %b expected 0", S0); end
    n_checks++; if (R0 !== 1'b0) begin n_fail++; $display("FAIL reset_R: got %b expected 0", R0); end
    n_checks++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", if0.req_ready); end
    n_checks++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", if0.done); end
    n_checks++; if (if0.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", if0.err); end
    n_checks++; if (if0.q_shadow !== 1'b0) begin n_fail++; $display("FAIL reset_qshadow: got %b expected 0", if0.q_shadow); end
    n_checks++; if (if1.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b expected 1", if1.req_ready); end
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++; if (if0.req_ready !== 1'b1 || if0.done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got ready=%b done=%b expected ready=1 done=0", if0.req_ready, if0.done);
    end
    mq0 = 1'b0;
    mq1 = 1'b0;
  endtask

  // Table-driven directed commands on the SETTLE_CYC=1 driver.
  task automatic test_directed(input string name, input logic [1:0] op0, input logic [1:0] op1,
                               input logic [1:0] op2, input int nops);
    logic [1:0] ops [3];
    bit acc; int ns, nr, fp, dk, dc, ov; logic e, qs, tgt; int ens, enr;
    ops[0] = op0; ops[1] = op1; ops[2] = op2;
    for (int i = 0; i < nops; i++) begin
      tgt = model_target(ops[i], mq0);
      ens = (ops[i] != 2'b00 && tgt) ? 1 : 0;
      enr = (ops[i] != 2'b00 && !tgt) ? 1 : 0;
      capture(0, ops[i], 0, acc, ns, nr, fp, dk, dc, e, qs, ov);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL %s[%0d]_accept: got %0d expected 1", name, i, acc); end
      n_checks++; if (ns !== ens) begin n_fail++; $display("FAIL %s[%0d]_S_pulses: got %0d expected %0d", name, i, ns, ens); end
      n_checks++; if (nr !== enr) begin n_fail++; $display("FAIL %s[%0d]_R_pulses: got %0d expected %0d", name, i, nr, enr); end
      n_checks++; if (fp !== ((ens + enr) > 0 ? 1 : 0)) begin n_fail++; $display("FAIL %s[%0d]_pulse_cycle: got %0d expected %0d", name, i, fp, (ens + enr) > 0 ? 1 : 0); end
      n_checks++; if (dk !== model_done_k(ops[i], 1, 1)) begin n_fail++; $display("FAIL %s[%0d]_done_cycle: got %0d expected %0d", name, i, dk, model_done_k(ops[i], 1, 1)); end
      n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL %s[%0d]_done_count: got %0d expected 1", name, i, dc); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL %s[%0d]_err: got %b expected 0", name, i, e); end
      n_checks++; if (qs !== tgt) begin n_fail++; $display("FAIL %s[%0d]_qshadow: got %b expected %b", name, i, qs, tgt); end
      n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL %s[%0d]_S_and_R: got %0d overlaps expected 0", name, i, ov); end
      mq0 = tgt;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3];
    int acc_c[$];
    string seq;
    int ndone, ov, idx, c;
    ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b01;
    seq = ""; ndone = 0; ov = 0; idx = 0; c = 0;
    @(negedge clk);
    req_sel = 0;
    req_op = ops[0];
    req_valid = 1'b1;
    #1;
    while (c < 40) begin
      if (o_S) seq = {seq, "S"};
      if (o_R) seq = {seq, "R"};
      if (o_S && o_R) ov++;
      if (o_done) ndone++;
      if (req_valid && o_ready) begin
        acc_c.push_back(c);
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx >= 3) req_valid = 1'b0;
      else req_op = ops[idx];
      @(negedge clk);
      c++;
    end
    req_valid = 1'b0;
    n_checks++; if (acc_c.size() !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", acc_c.size()); end
    n_checks++; if (acc_c.size() < 3 || (acc_c[1] - acc_c[0]) !== 5) begin n_fail++; $display("FAIL b2b_gap1: got %0d accepts, gap not 5 cycles", acc_c.size()); end
    n_checks++; if (acc_c.size() < 3 || (acc_c[2] - acc_c[1]) !== 5) begin n_fail++; $display("FAIL b2b_gap2: got %0d accepts, gap not 5 cycles", acc_c.size()); end
    n_checks++; if (seq != "SRS") begin n_fail++; $display("FAIL b2b_pulse_order: got %s expected SRS", seq); end
    n_checks++; if (ndone !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", ndone); end
    n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL b2b_S_and_R: got %0d expected 0", ov); end
    mq0 = 1'b1;
  endtask

  task automatic test_fault();
    bit acc; int ns, nr, fp, dk, dc, ov; logic e, qs;
    capture(0, 2'b10, 0, acc, ns, nr, fp, dk, dc, e, qs, ov);
    mq0 = 1'b0;
    force_en = 1'b1;
    capture(0, 2'b01, 0, acc, ns, nr, fp, dk, dc, e, qs, ov);
    force_en = 1'b0;
    n_checks++; if (ns !== FAULT_ATTEMPTS) begin n_fail++; $display("FAIL fault_S_pulses: got %0d expected %0d", ns, FAULT_ATTEMPTS); end
    n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL fault_R_pulses: got %0d expected 0", nr); end
    n_checks++; if (dk !== model_done_k(2'b01, FAULT_ATTEMPTS, 1)) begin n_fail++; $display("FAIL fault_done_cycle: got %0d expected %0d", dk, model_done_k(2'b01, FAULT_ATTEMPTS, 1)); end
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL fault_done_count: got %0d expected 1", dc); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL fault_err: got %b expected 1", e); end
    n_checks++; if (qs !== 1'b0) begin n_fail++; $display("FAIL fault_qshadow: got %b expected 0", qs); end
    mq0 = 1'b1;
`ifdef SR_DRV_RETRY_EN
    capture(0, 2'b10, 0, acc, ns, nr, fp, dk, dc, e, qs, ov);
    mq0 = 1'b0;
    force_en = 1'b1;
    capture(0, 2'b01, 2, acc, ns, nr, fp, dk, dc, e, qs, ov);
    force_en = 1'b0;
    n_checks++; if (ns !== 2) begin n_fail++; $display("FAIL recover_S_pulses: got %0d expected 2", ns); end
    n_checks++; if (dk !== model_done_k(2'b01, 2, 1)) begin n_fail++; $display("FAIL recover_done_cycle: got %0d expected %0d", dk, model_done_k(2'b01, 2, 1)); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL recover_err: got %b expected 0", e); end
    n_checks++; if (qs !== 1'b1) begin n_fail++; $display("FAIL recover_qshadow: got %b expected 1", qs); end
    mq0 = 1'b1;
`endif
  endtask

  task automatic test_settle_zero();
    bit acc; int ns, nr, fp, dk, dc, ov; logic e, qs, tgt;
    logic [1:0] ops [2];
    ops[0] = 2'b01; ops[1] = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tgt = model_target(ops[i], mq1);
      capture(1, ops[i], 0, acc, ns, nr, fp, dk, dc, e, qs, ov);
      n_checks++; if ((ns + nr) !== 1 || ns !== (tgt ? 1 : 0)) begin n_fail++; $display("FAIL s0[%0d]_pulses: got S=%0d R=%0d expected S=%0d", i, ns, nr, tgt ? 1 : 0); end
      n_checks++; if (dk !== model_done_k(ops[i], 1, 0)) begin n_fail++; $display("FAIL s0[%0d]_done_cycle: got %0d expected %0d", i, dk, model_done_k(ops[i], 1, 0)); end
      n_checks++; if (e !== 1'b0 || qs !== tgt) begin n_fail++; $display("FAIL s0[%0d]_status: got err=%b qs=%b expected err=0 qs=%b", i, e, qs, tgt); end
      n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL s0[%0d]_S_and_R: got %0d expected 0", i, ov); end
      mq1 = tgt;
    end
    req_sel = 0;
  endtask

  task automatic test_random();
    bit acc; int ns, nr, fp, dk, dc, ov; logic e, qs, tgt; logic [1:0] op;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      tgt = model_target(op, mq0);
      capture(0, op, 0, acc, ns, nr, fp, dk, dc, e, qs, ov);
      n_checks++; if (ns !== ((op != 2'b00 && tgt) ? 1 : 0) || nr !== ((op != 2'b00 && !tgt) ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd[%0d]_op%0d_pulses: got S=%0d R=%0d target=%b", i, op, ns, nr, tgt);
      end
      n_checks++; if (dk !== model_done_k(op, 1, 1) || dc !== 1) begin
        n_fail++; $display("FAIL rnd[%0d]_op%0d_done: got cycle=%0d count=%0d expected cycle=%0d count=1", i, op, dk, dc, model_done_k(op, 1, 1));
      end
      n_checks++; if (e !== 1'b0 || qs !== tgt || o_qs !== tgt) begin
        n_fail++; $display("FAIL rnd[%0d]_op%0d_status: got err=%b qs=%b qs_after=%b expected err=0 qs=%b", i, op, e, qs, o_qs, tgt);
      end
      n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL rnd[%0d]_S_and_R: got %0d expected 0", i, ov); end
      mq0 = tgt;
    end
  endtask

  task automatic test_reset_mid_drive();
    int ndone;
    ndone = 0;
    @(negedge clk);
    req_sel = 0;
    req_op = 2'b01;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_checks++; if (S0 !== 1'b1) begin n_fail++; $display("FAIL middrive_S_before: got %b expected 1", S0); end
    n_rst = 1'b0;
    #1;
    n_checks++; if (S0 !== 1'b0) begin n_fail++; $display("FAIL middrive_S_cut: got %b expected 0", S0); end
    n_checks++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL middrive_ready: got %b expected 1", if0.req_ready); end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if0.done) ndone++;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL middrive_no_done: got %0d done cycles expected 0", ndone); end
    mq0 = 1'b0;
    mq1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed("set_reset", 2'b01, 2'b10, 2'b00, 2);
    test_directed("toggle_hold", 2'b11, 2'b11, 2'b00, 3);
    test_back_to_back();
    test_fault();
    test_settle_zero();
    test_random();
    test_reset_mid_drive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
